// File: rtl/led_fade_if.sv
// Connects the blink sequencer (master) to the LED fade/PWM output stage (slave).
// These signals carry levels, not transactions. There is no valid/ready pair:
// the output stage samples led_in, max_duty and fade_en on every sys_clk edge,
// and led_out/fading are registered levels that are valid on every cycle.
interface led_fade_if #(
  parameter int PWM_BITS = 8
);
  logic [2:0]          led_in;
  logic [PWM_BITS-1:0] max_duty;
  logic                fade_en;
  logic [2:0]          led_out;
  logic                fading;

  modport master (
    output led_in,
    output max_duty,
    output fade_en,
    input  led_out,
    input  fading
  );

  modport slave (
    input  led_in,
    input  max_duty,
    input  fade_en,
    output led_out,
    output fading
  );
endinterface

// File: rtl/led_fade_pwm.sv
// Three-channel LED output stage. It turns the active-low on/off pattern into a PWM
// drive, and each channel's duty ramps toward its target by one step per fade tick.
// A duty change takes effect only at a PWM period boundary, so no pulse is ever cut short.
module led_fade_pwm #(
  parameter int PWM_BITS = 8,
  parameter int FADE_DIV = 23437
) (
  input logic        sys_clk,
  input logic        sys_rst_n,
  led_fade_if.slave  bus
);

  localparam int DIV_W = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(FADE_DIV - 1);
  // The period is 2^PWM_BITS-1 clocks, so the counter never reaches the full-scale value
  // and a duty of full scale keeps the channel lit.
  localparam logic [PWM_BITS-1:0] CNT_LAST = {{(PWM_BITS-1){1'b1}}, 1'b0};

  logic [PWM_BITS-1:0] pwm_cnt;
  logic [DIV_W-1:0]    div;
  logic                tick;
  logic                period_end;
  logic [PWM_BITS-1:0] duty        [3];
  logic [PWM_BITS-1:0] active_duty [3];
  logic [PWM_BITS-1:0] tgt         [3];
  logic                any_off;
  logic [2:0]          led_q;
  logic                fading_q;

  assign tick       = (div == DIV_LAST);
  assign period_end = (pwm_cnt == CNT_LAST);

  // Per-channel target from the current pattern, and whether any channel is still away from its target.
  always_comb begin
    any_off = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tgt[i] = bus.led_in[i] ? '0 : bus.max_duty;
      if (duty[i] != tgt[i]) any_off = 1'b1;
    end
  end

  // PWM period counter: 0..2^PWM_BITS-2, then wraps.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)      pwm_cnt <= '0;
    else if (period_end) pwm_cnt <= '0;
    else                 pwm_cnt <= pwm_cnt + 1'b1;
  end

  // Free-running fade divider. It keeps counting when fading is disabled, so tick phase stays steady.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) div <= '0;
    else if (tick)  div <= '0;
    else            div <= div + 1'b1;
  end

  // Duty update: snap to target when fading is off, otherwise move one step per tick toward target.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < 3; i++) duty[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (!bus.fade_en)            duty[i] <= tgt[i];
        else if (tick) begin
          if (duty[i] < tgt[i])      duty[i] <= duty[i] + 1'b1;
          else if (duty[i] > tgt[i]) duty[i] <= duty[i] - 1'b1;
        end
      end
    end
  end

  // Latch duty into the compare register at the period boundary.
  // If a tick lands on the same edge, this captures the value from before the step.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < 3; i++) active_duty[i] <= '0;
    end else if (period_end) begin
      for (int i = 0; i < 3; i++) active_duty[i] <= duty[i];
    end
  end

  // Registered active-low PWM compare, plus the registered fading flag.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      led_q    <= 3'b111;
      fading_q <= 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) led_q[i] <= ~(pwm_cnt < active_duty[i]);
      fading_q <= any_off;
    end
  end

  assign bus.led_out = led_q;
  assign bus.fading  = fading_q;

endmodule

// File: tb/tb_led_fade_pwm.sv
// Bench for led_fade_pwm. Two instances share the same inputs: one with FADE_DIV=4 and one
// with FADE_DIV=1. A behavioural model works out the expected outputs from the cycle count
// since reset and is compared against both instances on every negative clock edge.
module tb_led_fade_pwm;

  // ---------------- clock / reset ----------------
  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic [2:0] led_in   = 3'b111;
  logic [7:0] max_duty = 8'd0;
  logic       fade_en  = 1'b0;

  always #5 clk = ~clk;

  led_fade_if #(.PWM_BITS(8)) if0 ();
  led_fade_if #(.PWM_BITS(8)) if1 ();

  assign if0.led_in   = led_in;
  assign if0.max_duty = max_duty;
  assign if0.fade_en  = fade_en;
  assign if1.led_in   = led_in;
  assign if1.max_duty = max_duty;
  assign if1.fade_en  = fade_en;

  led_fade_pwm #(.PWM_BITS(8), .FADE_DIV(4)) u_dut4 (.sys_clk(clk), .sys_rst_n(rst_n), .bus(if0));
  led_fade_pwm #(.PWM_BITS(8), .FADE_DIV(1)) u_dut1 (.sys_clk(clk), .sys_rst_n(rst_n), .bus(if1));

  logic [2:0] d_led [2];
  logic       d_fad [2];
  assign d_led[0] = if0.led_out;
  assign d_led[1] = if1.led_out;
  assign d_fad[0] = if0.fading;
  assign d_fad[1] = if1.fading;

  int n_cmp;
  int n_bad;

  // ---------------- behavioural model ----------------
  // State after each edge is derived from the number of edges since reset: the PWM
  // position is cyc mod 255, and a fade tick falls where cyc mod FADE_DIV == FADE_DIV-1.
  int         m_duty [2][3];
  int         m_act  [2][3];
  logic [2:0] m_led  [2];
  logic       m_fad  [2];
  int         m_cyc  [2];

  function automatic int fd_of(input int k);
    return (k == 0) ? 4 : 1;
  endfunction

  function automatic int tgt_of(input int i);
    return led_in[i] ? 0 : int'(max_duty);
  endfunction

  function automatic int next_duty(input int d, input int t, input bit tk);
    if (!fade_en) return t;
    if (!tk) return d;
    if (d < t) return d + 1;
    if (d > t) return d - 1;
    return d;
  endfunction

  function automatic logic any_off(input int k);
    for (int i = 0; i < 3; i++) if (m_duty[k][i] != tgt_of(i)) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_cyc[k] <= 0;
        m_led[k] <= 3'b111;
        m_fad[k] <= 1'b0;
        for (int i = 0; i < 3; i++) begin
          m_duty[k][i] <= 0;
          m_act[k][i]  <= 0;
        end
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        for (int i = 0; i < 3; i++) begin
          m_led[k][i] <= ((m_cyc[k] % 255) >= m_act[k][i]);
          if ((m_cyc[k] % 255) == 254) m_act[k][i] <= m_duty[k][i];
          m_duty[k][i] <= next_duty(m_duty[k][i], tgt_of(i), (m_cyc[k] % fd_of(k)) == fd_of(k) - 1);
        end
        m_fad[k] <= any_off(k);
        m_cyc[k] <= m_cyc[k] + 1;
      end
    end
  end

  // ---------------- scoreboard / driver tasks ----------------
  // Every cycle of waiting goes through next_cyc, which compares both instances with the model.
  task automatic next_cyc();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (d_led[k] !== m_led[k]) begin
        n_bad++;
        $display("FAIL led_out inst%0d t=%0t: dut=%b model=%b", k, $time, d_led[k], m_led[k]);
      end
      n_cmp++;
      if (d_fad[k] !== m_fad[k]) begin
        n_bad++;
        $display("FAIL fading inst%0d t=%0t: dut=%b model=%b", k, $time, d_fad[k], m_fad[k]);
      end
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) next_cyc();
  endtask

  task automatic check(input string name, input int act, input int lo, input int hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Counts lit cycles of one channel over one full PWM period.
  task automatic count_lit(input int k, input int ch, output int n);
    n = 0;
    repeat (255) begin
      next_cyc();
      if (!d_led[k][ch]) n++;
    end
  endtask

  // Counts consecutive cycles with fading high, stopping at the first low sample or at the limit.
  task automatic measure_fading(input int k, input int limit, output int dur);
    dur = 0;
    for (int c = 0; c < limit; c++) begin
      next_cyc();
      if (d_fad[k]) dur++;
      else break;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n, dur0, dur1, bad_cnt;
    bit done0, done1;
    n_cmp = 0;
    n_bad = 0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_led_out", int'(d_led[0]), 7, 7);
    check("reset_fading", int'(d_fad[0]), 0, 0);
    rst_n = 1'b1;
    next_cyc();

    // Instant mode: channel 0 at half brightness.
    fade_en = 1'b0; max_duty = 8'd128; led_in = 3'b110;
    wait_cycles(600);
    count_lit(0, 0, n); check("instant_lit_ch0", n, 128, 128);
    count_lit(0, 1, n); check("instant_lit_ch1", n, 0, 0);
    count_lit(0, 2, n); check("instant_lit_ch2", n, 0, 0);
    count_lit(1, 0, n); check("instant_lit_ch0_div1", n, 128, 128);

    // Asynchronous reset with a channel lit, then one all-off period after release.
    @(posedge clk); #2; rst_n = 1'b0; #1;
    check("async_rst_led0", int'(d_led[0]), 7, 7);
    check("async_rst_fad0", int'(d_fad[0]), 0, 0);
    check("async_rst_led1", int'(d_led[1]), 7, 7);
    wait_cycles(3);
    rst_n = 1'b1;
    bad_cnt = 0;
    repeat (255) begin
      next_cyc();
      if (d_led[0] != 3'b111 || d_led[1] != 3'b111) bad_cnt++;
    end
    check("post_reset_first_period_off", bad_cnt, 0, 0);
    count_lit(0, 0, n); check("post_reset_second_period_lit", n, 128, 128);

    // Fade up 0->255 on both instances at once.
    fade_en = 1'b0; led_in = 3'b111; wait_cycles(5);
    fade_en = 1'b1; max_duty = 8'd255; led_in = 3'b110;
    dur0 = 0; dur1 = 0; done0 = 1'b0; done1 = 1'b0;
    for (int c = 0; c < 2000 && !(done0 && done1); c++) begin
      next_cyc();
      if (!done0) begin if (d_fad[0]) dur0++; else done0 = 1'b1; end
      if (!done1) begin if (d_fad[1]) dur1++; else done1 = 1'b1; end
    end
    check("fade_up_div4_cycles", dur0, 1016, 1024);
    check("fade_up_div1_cycles", dur1, 255, 255);
    check("fade_up_model_duty", m_duty[0][0], 255, 255);
    wait_cycles(600);
    count_lit(0, 0, n); check("fade_up_steady_lit", n, 255, 255);

    // Reverse mid-fade at duty 100.
    fade_en = 1'b0; led_in = 3'b111; wait_cycles(5);
    fade_en = 1'b1; max_duty = 8'd255; led_in = 3'b110;
    for (int c = 0; c < 2000 && m_duty[0][0] != 100; c++) next_cyc();
    check("reverse_reached_100", m_duty[0][0], 100, 100);
    led_in = 3'b111;
    measure_fading(0, 2000, dur0);
    check("reverse_down_cycles", dur0, 396, 404);
    check("reverse_model_duty", m_duty[0][0], 0, 0);

    // Sequencer rotation: ch0 falls 64->0 while ch1 rises 0->64.
    fade_en = 1'b0; max_duty = 8'd64; led_in = 3'b110; wait_cycles(5);
    fade_en = 1'b1; led_in = 3'b101;
    measure_fading(0, 2000, dur0);
    check("rotation_cycles", dur0, 252, 260);
    check("rotation_model_ch0", m_duty[0][0], 0, 0);
    check("rotation_model_ch1", m_duty[0][1], 64, 64);

    // Zero brightness with every channel requested on.
    max_duty = 8'd0; led_in = 3'b000; fade_en = 1'b1;
    wait_cycles(600);
    bad_cnt = 0;
    repeat (300) begin
      next_cyc();
      for (int k = 0; k < 2; k++) if (d_led[k] != 3'b111 || d_fad[k]) bad_cnt++;
    end
    check("zero_max_duty_dark", bad_cnt, 0, 0);

    // Randomised pattern, brightness and mode changes, checked against the model every cycle.
    repeat (40) begin
      led_in   = 3'($urandom_range(0, 7));
      max_duty = 8'($urandom_range(0, 255));
      fade_en  = 1'($urandom_range(0, 1));
      wait_cycles($urandom_range(1, 300));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/led_fade_pwm.md
Name: led_fade_pwm

Overview:
Downstream output stage for the RGB blink sequencer. It takes the sequencer's 3-bit active-low on/off pattern and drives the board LEDs with PWM. Each channel fades smoothly between off and a programmable brightness instead of snapping. It sits between the pattern generator and the LED pins.

Parameters:
PWM_BITS, 8, width of duty/PWM counter; PWM period = 2^PWM_BITS-1 = 255 clocks (~94 kHz at 24 MHz)
FADE_DIV, 23437, sys_clk cycles per fade step (~1024 steps/s; full 0->255 fade ~0.25 s); legal range >= 1

Ports:
sys_clk  in  1  24 MHz system clock
sys_rst_n  in  1  reset, asynchronous, active-low
led_in  in  3  pattern from sequencer, active-low per channel (0 = channel on), synchronous to sys_clk
max_duty  in  PWM_BITS  on-brightness target, 0..255
fade_en  in  1  1 = ramp duty toward target; 0 = duty jumps to target
led_out  out  3  PWM LED drive, active-low (0 = lit)
fading  out  1  1 while any channel duty != its target

Behaviour:
- Reset (async, sys_rst_n=0): pwm_cnt=0, fade div=0, duty[2:0]=0, active_duty[2:0]=0, led_out=3'b111, fading=0. All state is held in reset while sys_rst_n=0. Normal operation resumes on the first clock edge after deassertion.
- PWM counter: pwm_cnt counts 0..254 and wraps 254->0. Period is exactly 255 clocks.
- Period boundary: on the cycle pwm_cnt==254, active_duty[i] <= duty[i]. Duty changes take effect only at period start, so no glitched pulses.
- Output: led_out[i] is registered as ~(pwm_cnt < active_duty[i]), giving 1-cycle latency from the compare.
  - active_duty=0: channel never lit.
  - active_duty=255: channel lit every cycle, because pwm_cnt never reaches 255.
  - Lit cycles per period = active_duty.
- Target: tgt[i] = (led_in[i]==0) ? max_duty : 0. It is combinational from the current inputs and re-evaluated every cycle.
- Fade tick:
  - div counts 0..FADE_DIV-1; tick=1 on the cycle div==FADE_DIV-1, after which div wraps to 0.
  - FADE_DIV=1 gives a tick every cycle.
  - div runs freely regardless of fade_en.
- Duty update, per channel, independently:
  - fade_en=0: duty[i] <= tgt[i] every cycle.
  - fade_en=1 and tick: duty[i] +1 if duty<tgt, -1 if duty>tgt, hold if equal. Step size is always 1; no overshoot or wrap.
  - fade_en=1 and no tick: hold.
- Mid-fade events:
  - Target change mid-fade (led_in flips or max_duty changes): ramp reverses or retargets from the current duty. No restart from 0.
  - fade_en 1->0 mid-fade: duty jumps to tgt on the next edge.
- Simultaneous tick and period boundary: active_duty latches the pre-update duty. The stepped value appears at the next boundary.
- fading: registered, = OR over i of (duty[i] != tgt[i]), evaluated on current values. Goes 0 the cycle after the last channel reaches target.
- No ramp until the first boundary: after reset, led_out stays 3'b111 until active_duty becomes nonzero at a period boundary.

Test Plan:
- Reset: assert sys_rst_n=0 mid-run with channels lit -> led_out=3'b111, fading=0 immediately (async). After release, first 255-cycle period is all-off.
- Instant mode: FADE_DIV=4, fade_en=0, max_duty=128, led_in=3'b110 -> duty[0]=128 next edge. From the following period, led_out[0]=0 for exactly 128 of 255 cycles; led_out[2:1]=2'b11 constantly.
- Fade up:
  - Setup: FADE_DIV=4, fade_en=1, max_duty=255, led_in 3'b111->3'b110.
  - Required: duty[0] reaches 255 after 255 ticks (1020 +/-4 cycles); fading=1 throughout, 0 after.
  - Steady state: led_out[0]=0 every cycle.
- Reverse mid-fade: as above, switch led_in back to 3'b111 when duty[0]=100 -> duty[0] decreases 100->0 in 100 ticks (400 +/-4 cycles); no jump to 0 or 255.
- Sequencer rotation:
  - Setup: fade_en=1, max_duty=64, led_in 3'b110->3'b101.
  - Required: ch0 ramps 64->0 while ch1 ramps 0->64 in the same 64 ticks; fading deasserts once both finish.
- Boundaries: max_duty=0 with led_in=3'b000 -> led_out=3'b111 always, fading=0. FADE_DIV=1 full ramp 0->255 completes in 255 cycles.
